imem_loader: RTL
================

# imem_loader

Boot-time program loader for the multi-cycle MIPS core: the write side of the instruction memory, which the CPU only reads. It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit words, writes them to consecutive word addresses of instruction memory, and holds the CPU in reset until the image is complete. It sits between the external byte source (UART receiver or testbench) and the instruction-memory write port.

## Interface
- DEPTH, 1024: instruction memory size in words; maximum loadable word count.
- BASE_ADDR, 32'h0000_0000: byte address of the first word written; must be word aligned.

- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high; sampled on rising edge of clk.
- start  in  1  begin a load; honoured only in IDLE, DONE, ERR.
- byte_valid  in  1  source presents byte_data.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts a byte this cycle; a transfer occurs when byte_valid && byte_ready.
- mem_we  out  1  one-cycle write strobe to instruction memory.
- mem_addr  out  32  byte address; bits [1:0] always 00. Memory indexes with addr[31:2].
- mem_data  out  32  assembled instruction word.
- cpu_hold  out  1  high keeps the CPU (pc, gr) in reset.
- done  out  1  image fully written.
- error  out  1  header word count exceeded DEPTH.
- words_loaded  out  11  count of words written in the current load.

## Operation
- Stream format: 2-byte header (word count N, high byte first), then 4*N data bytes, big-endian (first byte goes to mem_data[31:24]).
- States: IDLE, HDR_HI, HDR_LO, DATA, WRITE, DONE, ERR.
- IDLE: byte_ready=0. start -> HDR_HI.
- HDR_HI: byte_ready=1. On transfer, latch N[15:8] -> HDR_LO.
- HDR_LO: byte_ready=1. On transfer, latch N[7:0]. N==0 -> DONE. N>DEPTH -> ERR. Otherwise clear byte index and word index -> DATA.
- DATA: byte_ready=1. On each transfer, shift the byte into the assembly register and increment a 2-bit byte index. The 4th byte (index 3) -> WRITE.
- WRITE: byte_ready=0. mem_we=1, mem_addr=BASE_ADDR+4*idx, mem_data=assembled word, all for exactly one cycle. idx and words_loaded increment. If idx+1==N -> DONE, else -> DATA.
- DONE: done=1, cpu_hold=0, byte_ready=0. Further stream bytes are ignored (not accepted).
- ERR: error=1, cpu_hold=1, byte_ready=0. No memory write occurs in a failed load.
- start in DONE or ERR: clear done, error and words_loaded, raise cpu_hold -> HDR_HI. start in other states is ignored.
- mem_addr and mem_data hold their last values when mem_we=0. Address arithmetic is 32-bit and wraps modulo 2^32; it is reachable only if BASE_ADDR is misconfigured.

## Timing
- Reset values: state IDLE, byte_ready=0, mem_we=0, mem_addr=0, mem_data=0, cpu_hold=1, done=0, error=0, words_loaded=0.
- Reset has priority over start and over any transfer in the same cycle. Reset mid-load aborts with no further mem_we. Words already written stay in memory.
- start at edge t: byte_ready=1 from cycle t+1.
- 4th data byte accepted at edge t: mem_we=1 during cycle t+1. The next byte can be accepted at edge t+2 at the earliest.
- Peak throughput: 5 cycles per word. Total minimum load time: 1 + 2 + 5N cycles from start to done.
- done and cpu_hold=0 take effect in the cycle after the final WRITE cycle.
- Source stalls (byte_valid=0) may occur at any point. The loader waits indefinitely, with no timeout.
- byte_data is sampled only on a transfer. Bytes presented while byte_ready=0 must be held by the source.

## Test plan
- Reset: assert reset for 2 cycles -> cpu_hold=1, byte_ready=0, mem_we=0, done=0, error=0, words_loaded=0.
- Basic load: start, then stream 00 02 12 34 56 78 9A BC DE F0 with byte_valid held high -> exactly two mem_we pulses: (addr 0x0, 0x12345678) and (addr 0x4, 0x9ABCDEF0). Then done=1, cpu_hold=0, words_loaded=2. Total cycles = 13.
- Stalls and backpressure: same stream with byte_valid toggling pseudo-randomly, and a byte presented during the WRITE cycle -> identical writes. That byte is accepted only after WRITE, with no loss or duplication.
- Empty image: stream 00 00 -> done=1 the cycle after the header, no mem_we, words_loaded=0. A trailing byte is not accepted.
- Oversize: stream 04 01 (N=1025, DEPTH=1024) -> error=1, cpu_hold=1, no mem_we. A subsequent start and valid 1-word image -> error clears, write at 0x0, then done.
- Reset mid-load: reset after the 2nd data byte of word 1 -> no mem_we afterward, IDLE outputs restored. A new load then writes its first word at BASE_ADDR.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream handshake and instruction-memory write port of the boot loader.
// The slave side belongs to the loader; the master side drives bytes and observes writes.
interface imem_loader_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;

    modport master (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_data
    );

    modport slave (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output mem_we,
        output mem_addr,
        output mem_data
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: header word count, then big-endian words
// written to consecutive addresses while the CPU is held in reset.
module imem_loader #(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    imem_loader_if.slave bus,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [10:0] words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_HI,
        S_HDR_LO,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  hdr_hi_q, hdr_hi_d;
    logic [15:0] count_q, count_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [10:0] words_q, words_d;
    logic [23:0] asm_q, asm_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_data_q, mem_data_d;

    logic        xfer;
    logic [15:0] hdr_n;

    assign bus.byte_ready = (state_q == S_HDR_HI) || (state_q == S_HDR_LO) || (state_q == S_DATA);
    assign xfer           = bus.byte_valid && bus.byte_ready;
    assign hdr_n          = {hdr_hi_q, bus.byte_data};

    assign bus.mem_we     = (state_q == S_WRITE);
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_data   = mem_data_q;
    assign cpu_hold       = (state_q != S_DONE);
    assign done           = (state_q == S_DONE);
    assign error          = (state_q == S_ERR);
    assign words_loaded   = words_q;

    always_comb begin
        state_d    = state_q;
        hdr_hi_d   = hdr_hi_q;
        count_d    = count_q;
        byte_idx_d = byte_idx_q;
        words_d    = words_q;
        asm_d      = asm_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    words_d = '0;
                    state_d = S_HDR_HI;
                end
            end
            S_HDR_HI: begin
                if (xfer) begin
                    hdr_hi_d = bus.byte_data;
                    state_d  = S_HDR_LO;
                end
            end
            S_HDR_LO: begin
                if (xfer) begin
                    count_d = hdr_n;
                    if (hdr_n == 16'd0) begin
                        state_d = S_DONE;
                    end else if ({16'd0, hdr_n} > DEPTH) begin
                        state_d = S_ERR;
                    end else begin
                        byte_idx_d = '0;
                        words_d    = '0;
                        state_d    = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    asm_d      = {asm_q[15:0], bus.byte_data};
                    byte_idx_d = byte_idx_q + 2'd1;
                    // The address/data registers only move here so they hold steady outside WRITE.
                    if (byte_idx_q == 2'd3) begin
                        mem_data_d = {asm_q, bus.byte_data};
                        mem_addr_d = BASE_ADDR + {19'd0, words_q, 2'b00};
                        state_d    = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                words_d = words_q + 11'd1;
                if (({5'd0, words_q} + 16'd1) == count_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_DONE, S_ERR: begin
                if (start) begin
                    words_d = '0;
                    state_d = S_HDR_HI;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            hdr_hi_q   <= '0;
            count_q    <= '0;
            byte_idx_q <= '0;
            words_q    <= '0;
            asm_q      <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            state_q    <= state_d;
            hdr_hi_q   <= hdr_hi_d;
            count_q    <= count_d;
            byte_idx_q <= byte_idx_d;
            words_q    <= words_d;
            asm_q      <= asm_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
        end
    end

endmodule
